// File: rtl/mant_div_r2_if.sv
// Handshake/data bundle for the radix-2 mantissa divider.
// Signals: start_i/n_i/d_i (request), busy_o/valid_o (status),
//          q_o/rem_nz_o/div_zero_o (result, valid while valid_o is high).
interface mant_div_r2_if #(
  parameter int WIDTH = 24
);
  logic             start_i;
  logic [WIDTH-1:0] n_i;
  logic [WIDTH-1:0] d_i;
  logic             busy_o;
  logic             valid_o;
  logic [WIDTH+1:0] q_o;
  logic             rem_nz_o;
  logic             div_zero_o;

  // Requester side: issues start with operands, observes status and result.
  modport master (
    output start_i, n_i, d_i,
    input  busy_o, valid_o, q_o, rem_nz_o, div_zero_o
  );

  // Divider side.
  modport slave (
    input  start_i, n_i, d_i,
    output busy_o, valid_o, q_o, rem_nz_o, div_zero_o
  );
endinterface

// File: rtl/mant_div_r2.sv
// Sequential radix-2 restoring significand divider: q = floor(n * 2^(WIDTH+1) / d),
// one quotient bit per clock, plus sticky (remainder != 0) and divide-by-zero flags.
// Ports: clk_i, reset_i (async, active-low), bus (mant_div_r2_if.slave: start/operands in,
//        busy/valid/result out).
// Latency WIDTH+2 cycles from the start-sampling edge; start is ignored while busy.
// Optional macro MANT_DIV_EARLY_ZERO_EN: zero dividend/divisor completes one cycle after start.
module mant_div_r2 #(
  parameter int WIDTH = 24
) (
  input  logic         clk_i,
  input  logic         reset_i,
  mant_div_r2_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] d_q;      // latched divisor
  logic [WIDTH:0]   r_q;      // partial remainder, always < 2*D for in-contract divisors
  logic [WIDTH+1:0] q_sr;     // quotient shift register
  logic [CW-1:0]    cnt;
  logic             dz_q;     // divisor was zero

  logic             busy_r;
  logic             valid_r;
  logic [WIDTH+1:0] q_r;
  logic             rem_nz_r;
  logic             div_zero_r;

  // One restoring step: compare, conditionally subtract, then shift left.
  // The shift naturally discards bit WIDTH, which is zero whenever a
  // subtraction happened and R < 2D holds.
  logic             ge;
  logic [WIDTH:0]   r_sub;
  logic [WIDTH:0]   r_sel;
  logic [WIDTH:0]   r_nxt;
  logic [WIDTH+1:0] q_nxt;

  always_comb begin
    ge    = (r_q >= {1'b0, d_q});
    r_sub = r_q - {1'b0, d_q};
    r_sel = ge ? r_sub : r_q;
    r_nxt = r_sel << 1;
    q_nxt = (q_sr << 1) | {{(WIDTH+1){1'b0}}, ge};
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state      <= IDLE;
      d_q        <= '0;
      r_q        <= '0;
      q_sr       <= '0;
      cnt        <= '0;
      dz_q       <= 1'b0;
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
      q_r        <= '0;
      rem_nz_r   <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          valid_r <= 1'b0;
          if (bus.start_i) begin
            d_q  <= bus.d_i;
            r_q  <= {1'b0, bus.n_i};
            q_sr <= '0;
            cnt  <= '0;
            dz_q <= (bus.d_i == '0);
`ifdef MANT_DIV_EARLY_ZERO_EN
            if (bus.n_i == '0 || bus.d_i == '0) begin
              // Result is known without iterating; publish it directly.
              state      <= DONE;
              busy_r     <= 1'b0;
              valid_r    <= 1'b1;
              q_r        <= (bus.d_i == '0) ? '1 : '0;
              rem_nz_r   <= 1'b0;
              div_zero_r <= (bus.d_i == '0);
            end else begin
              state  <= RUN;
              busy_r <= 1'b1;
            end
`else
            state  <= RUN;
            busy_r <= 1'b1;
`endif
          end else begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end

        RUN: begin
          r_q  <= r_nxt;
          q_sr <= q_nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST_STEP) begin
            state      <= DONE;
            busy_r     <= 1'b0;
            valid_r    <= 1'b1;
            // A zero divisor still iterates, but the result is forced.
            q_r        <= dz_q ? '1 : q_nxt;
            rem_nz_r   <= dz_q ? 1'b0 : (|r_nxt);
            div_zero_r <= dz_q;
          end
        end

        default: begin
          state   <= IDLE;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o     = busy_r;
  assign bus.valid_o    = valid_r;
  assign bus.q_o        = q_r;
  assign bus.rem_nz_o   = rem_nz_r;
  assign bus.div_zero_o = div_zero_r;

endmodule
